// File: rtl/immgen_pipe.sv
// immgen_pipe: pipelined RV immediate generator.
//
// Decodes the immediate format from the opcode of a raw 32-bit instruction.
// The result is an XLEN-wide sign-extended immediate, a format code and an
// illegal flag. It passes through DEPTH register stages under valid/ready
// flow control. A sideband tag (PC, ROB index, ...) travels alongside each
// entry unchanged.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   flush             synchronous kill of every in-flight entry
//   in_valid/in_ready input handshake
//   in_instr, in_tag  raw instruction word and its sideband tag
//   out_valid/out_ready output handshake
//   out_imm           sign-extended immediate (XLEN bits)
//   out_fmt           0=I 1=S 2=B 3=U 4=J 5=R 6=Z(CSR zimm) 7=none
//   out_illegal       opcode not recognised
//   out_tag           tag of the entry on the output
//
// Optional feature: define IMMGEN_ZICSR_EN to decode CSR immediate forms
// (SYSTEM, funct3 101/110/111) as fmt 6 with a zero-extended rs1-field zimm.
module immgen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [2:0] {
    FMT_I    = 3'd0,
    FMT_S    = 3'd1,
    FMT_B    = 3'd2,
    FMT_U    = 3'd3,
    FMT_J    = 3'd4,
    FMT_R    = 3'd5,
    FMT_Z    = 3'd6,
    FMT_NONE = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  logic [6:0]      opcode;
  fmt_e            dec_fmt;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;

  assign opcode = in_instr[6:0];

  // Combinational decode feeding stage 0. Each immediate is assembled at its
  // natural width as a signed value; the size cast sign-extends it to XLEN.
  // Opcodes whose low bits are not 2'b11 are compressed or reserved. They
  // never match a case item, so they fall into the illegal default.
  always_comb begin
    dec_fmt     = FMT_NONE;
    dec_imm     = '0;
    dec_illegal = 1'b0;
    case (opcode)
      OP_LOAD, OP_MISC_MEM, OP_OP_IMM, OP_JALR, OP_SYSTEM: begin
        dec_fmt = FMT_I;
        dec_imm = XLEN'($signed(in_instr[31:20]));
      end
      OP_STORE: begin
        dec_fmt = FMT_S;
        dec_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      end
      OP_BRANCH: begin
        dec_fmt = FMT_B;
        dec_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                 in_instr[11:8], 1'b0}));
      end
      OP_LUI, OP_AUIPC: begin
        dec_fmt = FMT_U;
        dec_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
      end
      OP_JAL: begin
        dec_fmt = FMT_J;
        dec_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                 in_instr[30:21], 1'b0}));
      end
      OP_OP: begin
        dec_fmt = FMT_R;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
`ifdef IMMGEN_ZICSR_EN
    // CSR immediate forms carry a 5-bit unsigned zimm in the rs1 field.
    if (opcode == OP_SYSTEM && in_instr[14] && (in_instr[13:12] != 2'b00)) begin
      dec_fmt = FMT_Z;
      dec_imm = XLEN'(in_instr[19:15]);
    end
`endif
  end

  logic [DEPTH-1:0] stage_valid;
  logic [DEPTH-1:0] stage_load;
  logic [DEPTH-1:0] src_valid;
  logic [XLEN-1:0]  stage_imm     [DEPTH];
  logic [2:0]       stage_fmt     [DEPTH];
  logic             stage_illegal [DEPTH];
  logic [TAG_W-1:0] stage_tag     [DEPTH];
  logic [XLEN-1:0]  src_imm       [DEPTH];
  logic [2:0]       src_fmt       [DEPTH];
  logic             src_illegal   [DEPTH];
  logic [TAG_W-1:0] src_tag       [DEPTH];
  logic             run_full;

  // Source of each stage: the decoder for stage 0, otherwise the stage before.
  assign src_valid[0]   = in_valid;
  assign src_imm[0]     = dec_imm;
  assign src_fmt[0]     = dec_fmt;
  assign src_illegal[0] = dec_illegal;
  assign src_tag[0]     = in_tag;

  for (genvar k = 1; k < DEPTH; k++) begin : g_src
    assign src_valid[k]   = stage_valid[k-1];
    assign src_imm[k]     = stage_imm[k-1];
    assign src_fmt[k]     = stage_fmt[k-1];
    assign src_illegal[k] = stage_illegal[k-1];
    assign src_tag[k]     = stage_tag[k-1];
  end

  // Stage k may load when downstream is taking the output, or when some stage
  // from k to the output is empty. In that case everything between k and the
  // hole shifts forward by one. This is the unrolled form of the recursive
  // "empty or next accepts" rule. It avoids a self-referencing vector.
  always_comb begin
    stage_load = '0;
    run_full   = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      run_full = 1'b1;
      for (int j = k; j < DEPTH; j++) begin
        run_full = run_full & stage_valid[j];
      end
      stage_load[k] = out_ready | ~run_full;
    end
  end

  assign in_ready = stage_load[0];

  // Stage registers. Flush wins over any incoming entry and only clears the
  // valid bits. Data is captured only for real entries, so held outputs and
  // idle stages stay quiet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        stage_imm[k]     <= '0;
        stage_fmt[k]     <= '0;
        stage_illegal[k] <= 1'b0;
        stage_tag[k]     <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (stage_load[k]) begin
          stage_valid[k] <= src_valid[k] & ~flush;
          if (src_valid[k] && !flush) begin
            stage_imm[k]     <= src_imm[k];
            stage_fmt[k]     <= src_fmt[k];
            stage_illegal[k] <= src_illegal[k];
            stage_tag[k]     <= src_tag[k];
          end
        end else if (flush) begin
          stage_valid[k] <= 1'b0;
        end
      end
    end
  end

  assign out_valid   = stage_valid[DEPTH-1];
  assign out_imm     = stage_imm[DEPTH-1];
  assign out_fmt     = stage_fmt[DEPTH-1];
  assign out_illegal = stage_illegal[DEPTH-1];
  assign out_tag     = stage_tag[DEPTH-1];

endmodule

// File: tb/tb_immgen_pipe.sv
// tb_immgen_pipe: self-checking bench for immgen_pipe.
// Two instances share one stimulus stream:
//   dut1: XLEN=32, DEPTH=1
//   dut3: XLEN=64, DEPTH=3
// A scoreboard per instance holds the expected results of accepted entries.
// Those results come from an arithmetic reference decoder.
module tb_immgen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;
  logic [7:0]  in_tag;

  logic        rdy1, ov1, ill1;
  logic [31:0] imm1;
  logic [2:0]  fmt1;
  logic [7:0]  tag1;

  logic        rdy3, ov3, ill3;
  logic [63:0] imm3;
  logic [2:0]  fmt3;
  logic [7:0]  tag3;

  logic        rdy1_s, rdy3_s;
  int          n_checks = 0;
  int          n_errors = 0;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [7:0]  tag;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];

  always #5 clk = ~clk;

  immgen_pipe #(.XLEN(32), .DEPTH(1), .TAG_W(8)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy1), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(ov1), .out_ready(out_ready), .out_imm(imm1), .out_fmt(fmt1),
    .out_illegal(ill1), .out_tag(tag1)
  );

  immgen_pipe #(.XLEN(64), .DEPTH(3), .TAG_W(8)) dut3 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy3), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(ov3), .out_ready(out_ready), .out_imm(imm3), .out_fmt(fmt3),
    .out_illegal(ill3), .out_tag(tag3)
  );

  // Counts a comparison and reports it when the observed value differs.
  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Drives one cycle of input, then samples in_ready mid-cycle.
  // Returns just after the next rising edge.
  task automatic applyStimulus(input logic [31:0] ins, input logic [7:0] tag, input logic vld);
    in_instr = ins;
    in_tag   = tag;
    in_valid = vld;
    @(negedge clk);
    rdy1_s = rdy1;
    rdy3_s = rdy3;
    @(posedge clk);
    #1;
  endtask

  // Reference decoder. It works on the sign-extended word with shifts and
  // sums of the scattered immediate fields.
  function automatic exp_t ref_model(input logic [31:0] ins, input logic [7:0] tag, input int xlen);
    exp_t   e;
    longint s;
    longint v;
    int     op;
    s  = longint'($signed(ins));
    op = int'(ins[6:0]);
    v  = 0;
    e.fmt = 3'd7;
    e.ill = 1'b1;
    e.tag = tag;
    if (op inside {'h03, 'h0F, 'h13, 'h67, 'h73}) begin
      e.fmt = 3'd0; v = s >>> 20;
    end else if (op == 'h23) begin
      e.fmt = 3'd1; v = ((s >>> 25) <<< 5) + longint'(ins[11:7]);
    end else if (op == 'h63) begin
      e.fmt = 3'd2;
      v = ((s >>> 31) <<< 12) + (longint'(ins[7]) <<< 11) +
          (longint'(ins[30:25]) <<< 5) + (longint'(ins[11:8]) <<< 1);
    end else if (op == 'h37 || op == 'h17) begin
      e.fmt = 3'd3; v = (s >>> 12) <<< 12;
    end else if (op == 'h6F) begin
      e.fmt = 3'd4;
      v = ((s >>> 31) <<< 20) + (longint'(ins[19:12]) <<< 12) +
          (longint'(ins[20]) <<< 11) + (longint'(ins[30:21]) <<< 1);
    end else if (op == 'h33) begin
      e.fmt = 3'd5;
    end
    if (e.fmt != 3'd7) e.ill = 1'b0;
`ifdef IMMGEN_ZICSR_EN
    if (op == 'h73 && int'(ins[14:12]) >= 5) begin
      e.fmt = 3'd6; v = longint'(ins[19:15]);
    end
`endif
    e.imm = (xlen == 32) ? {32'b0, v[31:0]} : v;
    return e;
  endfunction

  // Scoreboard at the falling edge, describing the coming rising edge.
  // in_ready must be high when out_ready is high or the block holds fewer
  // than DEPTH entries. A handshaken output must match the oldest expected
  // entry. Flush and reset empty the model; a handshaken input is appended.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q1.delete();
      q3.delete();
    end else begin
      checkOutput("sb1_ready", rdy1, out_ready || q1.size() < 1);
      checkOutput("sb3_ready", rdy3, out_ready || q3.size() < 3);
      if (ov1 && out_ready) begin
        if (q1.size() == 0) checkOutput("sb1_spurious", ov1, 0);
        else begin
          e = q1.pop_front();
          checkOutput("sb1_imm", imm1, e.imm);
          checkOutput("sb1_fmt", fmt1, e.fmt);
          checkOutput("sb1_ill", ill1, e.ill);
          checkOutput("sb1_tag", tag1, e.tag);
        end
      end
      if (ov3 && out_ready) begin
        if (q3.size() == 0) checkOutput("sb3_spurious", ov3, 0);
        else begin
          e = q3.pop_front();
          checkOutput("sb3_imm", imm3, e.imm);
          checkOutput("sb3_fmt", fmt3, e.fmt);
          checkOutput("sb3_ill", ill3, e.ill);
          checkOutput("sb3_tag", tag3, e.tag);
        end
      end
      if (flush) begin
        q1.delete();
        q3.delete();
      end else begin
        if (in_valid && rdy1) q1.push_back(ref_model(in_instr, in_tag, 32));
        if (in_valid && rdy3) q3.push_back(ref_model(in_instr, in_tag, 64));
      end
    end
  end

`ifdef IMMGEN_ZICSR_EN
  localparam logic [31:0] CSR_IMM = 32'h0000_0005;
  localparam logic [2:0]  CSR_FMT = 3'd6;
`else
  localparam logic [31:0] CSR_IMM = 32'h0000_07C1;
  localparam logic [2:0]  CSR_FMT = 3'd0;
`endif

  logic [31:0] vec_ins [9] = '{32'hFFF00093, 32'hFE20AE23, 32'hFF9FF06F, 32'h123452B7,
                               32'h00000000, 32'h0000007F, 32'h7C12D073, 32'h00B50533,
                               32'hFE000EE3};
  logic [31:0] vec_imm [9] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000,
                               32'h0, 32'h0, CSR_IMM, 32'h0, 32'hFFFFFFFC};
  logic [2:0]  vec_fmt [9] = '{3'd0, 3'd1, 3'd4, 3'd3, 3'd7, 3'd7, CSR_FMT, 3'd5, 3'd2};
  logic        vec_ill [9] = '{0, 0, 0, 0, 1, 1, 0, 0, 0};

  int opc_list [11] = '{'h03, 'h0F, 'h13, 'h67, 'h73, 'h23, 'h63, 'h37, 'h17, 'h6F, 'h33};

  // Main sequence. It runs directed cases from the block's test plan, then
  // a long randomized stream with random backpressure and occasional flush.
  initial begin
    int          acc;
    int          seen;
    logic [7:0]  got_tags[$];
    logic [31:0] ins;
    int          sel;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_tag = '0;
    @(posedge clk);
    #1;
    checkOutput("rst_ov3", ov3, 0);
    checkOutput("rst_imm3", imm3, 0);
    checkOutput("rst_fmt3", fmt3, 0);
    checkOutput("rst_ill3", ill3, 0);
    checkOutput("rst_tag3", tag3, 0);
    checkOutput("rst_ov1", ov1, 0);
    checkOutput("rst_imm1", imm1, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(32'h0, 8'h0, 1'b0);
    checkOutput("post_rst_rdy1", rdy1, 1);
    checkOutput("post_rst_rdy3", rdy3, 1);

    // Known vectors on the single-stage instance: visible one edge later.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vec_ins[i], 8'(i + 16), 1'b1);
      checkOutput($sformatf("vec%0d_ov", i), ov1, 1);
      checkOutput($sformatf("vec%0d_imm", i), imm1, vec_imm[i]);
      checkOutput($sformatf("vec%0d_fmt", i), fmt1, vec_fmt[i]);
      checkOutput($sformatf("vec%0d_ill", i), ill1, vec_ill[i]);
    end

    // RV64 LUI sign extension and three-cycle latency on dut3.
    repeat (3) applyStimulus(32'h0, 8'h0, 1'b0);
    applyStimulus(32'h800002B7, 8'h77, 1'b1);
    applyStimulus(32'h0, 8'h0, 1'b0);
    checkOutput("lat3_early", ov3, 0);
    applyStimulus(32'h0, 8'h0, 1'b0);
    checkOutput("lat3_ov", ov3, 1);
    checkOutput("lui64_imm", imm3, 64'hFFFFFFFF80000000);
    checkOutput("lui64_fmt", fmt3, 3);
    checkOutput("lui64_tag", tag3, 8'h77);
    applyStimulus(32'h0, 8'h0, 1'b0);

    // Capacity under backpressure: five offers, only DEPTH accepted.
    out_ready = 1'b0;
    acc = 0;
    for (int t = 1; t <= 5; t++) begin
      applyStimulus(32'h00000093 | (32'(t) << 20), 8'(t), 1'b1);
      acc += int'(rdy3_s);
    end
    checkOutput("cap_accept", acc, 3);
    checkOutput("cap_rdy", rdy3, 0);
    for (int h = 0; h < 2; h++) begin
      applyStimulus(32'h0, 8'h0, 1'b0);
      checkOutput("hold_ov", ov3, 1);
      checkOutput("hold_tag", tag3, 1);
      checkOutput("hold_imm", imm3, 64'h1);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (ov3) got_tags.push_back(tag3);
      applyStimulus(32'h0, 8'h0, 1'b0);
    end
    checkOutput("drain_count", got_tags.size(), 3);
    for (int i = 0; i < got_tags.size() && i < 3; i++)
      checkOutput("drain_order", got_tags[i], 8'(i + 1));

    // Flush with a full pipe and a simultaneous input.
    out_ready = 1'b0;
    applyStimulus(32'h00100093, 8'h21, 1'b1);
    applyStimulus(32'h00200093, 8'h22, 1'b1);
    applyStimulus(32'h00300093, 8'h23, 1'b1);
    checkOutput("pre_flush_ov3", ov3, 1);
    flush = 1'b1;
    applyStimulus(32'h00400093, 8'hEE, 1'b1);
    flush = 1'b0;
    checkOutput("flush_rdy_ungated", rdy3_s, 0);
    checkOutput("flush_ov3", ov3, 0);
    checkOutput("flush_ov1", ov1, 0);
    checkOutput("flush_rdy3", rdy3, 1);
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (ov3) seen++;
      applyStimulus(32'h0, 8'h0, 1'b0);
    end
    checkOutput("flush_ghost", seen, 0);

    // Asynchronous reset with a full pipe, then latency of a fresh entry.
    out_ready = 1'b0;
    applyStimulus(32'h00500093, 8'h31, 1'b1);
    applyStimulus(32'h00600093, 8'h32, 1'b1);
    applyStimulus(32'h00700093, 8'h33, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("arst_ov3", ov3, 0);
    checkOutput("arst_imm3", imm3, 0);
    checkOutput("arst_fmt3", fmt3, 0);
    checkOutput("arst_ill3", ill3, 0);
    checkOutput("arst_tag3", tag3, 0);
    checkOutput("arst_ov1", ov1, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    applyStimulus(32'hABC00093, 8'h42, 1'b1);
    checkOutput("rel_rdy3", rdy3_s, 1);
    applyStimulus(32'h0, 8'h0, 1'b0);
    checkOutput("rel_early", ov3, 0);
    applyStimulus(32'h0, 8'h0, 1'b0);
    checkOutput("rel_ov3", ov3, 1);
    checkOutput("rel_tag3", tag3, 8'h42);
    checkOutput("rel_imm3", imm3, 64'hFFFFFFFFFFFFFABC);

    // Randomized stream.
    for (int n = 0; n < 3000; n++) begin
      ins = $urandom();
      sel = $urandom_range(0, 12);
      if (sel < 11) ins[6:0] = 7'(opc_list[sel]);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      applyStimulus(ins, 8'($urandom()), $urandom_range(0, 3) != 0);
    end
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (5) applyStimulus(32'h0, 8'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
